// File: rtl/ce_divider_flag.sv
// -----------------------------------------------------------------------------
// ce_divider_flag
//
// Single-clock helper for a cross-clock register transfer scheme.
//
//   * Enable generator: a 5-bit counter wraps at CLK_DIVIDE. Each wrap can raise
//     a one-cycle clock-enable pulse (ce). If EXTRA_DIV2 is "TRUE", a phase bit
//     lets only every second wrap through, which doubles the period.
//   * ce_toggle: inverts once per ce pulse. It is a level that a foreign clock
//     domain can sample safely, unlike the pulse itself.
//   * Flag receiver: synchronizes a toggle from a foreign domain through a
//     two-flop synchronizer, then an edge-detect flop. Every transition gives
//     one flag_out pulse that lasts one clock.
//
// Parameters
//   CLK_DIVIDE  terminal count (5 bit). The base ce period is CLK_DIVIDE+1 clocks.
//   EXTRA_DIV2  "TRUE" doubles the ce period. Any other string acts as "FALSE".
//
// Ports
//   clk             in   sole clock. All state updates on the rising edge.
//   rst_n           in   asynchronous, active-low reset.
//   clr             in   (CE_DIVIDER_SYNC_CLR_EN only) synchronous restart of
//                        the divider.
//   ce              out  registered one-cycle enable pulse.
//   ce_toggle       out  registered. Flips after each cycle in which ce is high.
//   flag_toggle_in  in   asynchronous toggle. Each transition is one event.
//   flag_out        out  one-cycle pulse per synchronized transition. It is the
//                        XOR of two flops, so the input has no direct path to it.
//
// Optional feature (macro CE_DIVIDER_SYNC_CLR_EN)
//   Adds the clr input. When clr is high at a rising edge, the counter, the
//   phase bit and ce are all cleared on that edge. clr wins over a wrap.
//   ce_toggle and the flag path ignore clr. After clr, the next ce comes at the
//   same point as it would after a reset release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ce_divider_flag #(
  parameter logic [4:0] CLK_DIVIDE = 5'd31,
  parameter string      EXTRA_DIV2 = "FALSE"
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CE_DIVIDER_SYNC_CLR_EN
  input  logic clr,
`endif
  output logic ce,
  output logic ce_toggle,
  input  logic flag_toggle_in,
  output logic flag_out
);

  // Only an exact "TRUE" turns on the divide-by-2. Any other string means off.
  localparam bit USE_DIV2 = (EXTRA_DIV2 == "TRUE");

  // ---------------------------------------------------------------------------
  // Synchronous clear. It is tied off when the feature is not built, so the
  // datapath below stays the same in both builds.
  // ---------------------------------------------------------------------------
  logic clr_w;
`ifdef CE_DIVIDER_SYNC_CLR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Terminal-count counter
  // ---------------------------------------------------------------------------
  logic [4:0] count_q;
  logic [4:0] count_d;
  logic       wrap_w;

  assign wrap_w = (count_q == CLK_DIVIDE);

  // The wrap uses the compare, not the natural 5-bit overflow. That way any
  // terminal count below 31 restarts at 0, and values above it never occur.
  always_comb begin
    count_d = count_q + 5'd1;
    if (wrap_w) begin
      count_d = '0;
    end
    if (clr_w) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional divide-by-2 phase. phase_ok_w qualifies the wrap that raises ce.
  // ---------------------------------------------------------------------------
  logic phase_ok_w;

  generate
    if (USE_DIV2) begin : g_div2
      logic phase_q;
      logic phase_d;

      // The phase flips at every wrap. ce only fires on wraps that find it
      // already set, so the first ce comes on the second wrap.
      always_comb begin
        phase_d = phase_q;
        if (wrap_w) begin
          phase_d = ~phase_q;
        end
        if (clr_w) begin
          phase_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          phase_q <= 1'b0;
        end else begin
          phase_q <= phase_d;
        end
      end

      assign phase_ok_w = phase_q;
    end else begin : g_no_div2
      assign phase_ok_w = 1'b1;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registered enable and its toggle form
  // ---------------------------------------------------------------------------
  logic ce_q;
  logic ce_d;
  logic ce_toggle_q;
  logic ce_toggle_d;

  always_comb begin
    ce_d = wrap_w & phase_ok_w;
    if (clr_w) begin
      ce_d = 1'b0;
    end
  end

  // ce_toggle looks at the registered ce. It flips on the edge that samples
  // ce high, one cycle after the pulse appears.
  assign ce_toggle_d = ce_toggle_q ^ ce_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q        <= 1'b0;
      ce_toggle_q <= 1'b0;
    end else begin
      ce_q        <= ce_d;
      ce_toggle_q <= ce_toggle_d;
    end
  end

  assign ce        = ce_q;
  assign ce_toggle = ce_toggle_q;

  // ---------------------------------------------------------------------------
  // Flag receive path
  // sync1/sync2 form the metastability chain. sync3 holds the previous settled
  // level for edge detection. The sender must hold each level for at least two
  // clocks, or two close transitions can merge into one.
  // ---------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;
  logic sync3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= flag_toggle_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // XOR of two flop outputs. It goes high for one cycle when the settled level
  // changes.
  assign flag_out = sync2_q ^ sync3_q;

endmodule

// File: tb/tb_ce_divider_flag.sv
// -----------------------------------------------------------------------------
// tb_ce_divider_flag
// Directed bench for ce_divider_flag. Several instances with different
// parameters share one clock, one reset and one flag input. After the n-th
// rising edge since reset release, a ce period P gives:
//   ce        = (n % P == 0)
//   ce_toggle = ((n-1) / P) % 2
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ce_divider_flag;

  logic clk;
  logic rst_n;
  logic flag_in;
  logic clr_off;
  logic clr;

  logic ce_d3,   tog_d3,   flag_d3;
  logic ce_d3x2, tog_d3x2, flag_d3x2;
  logic ce_d0,   tog_d0,   flag_d0;
  logic ce_d0x2, tog_d0x2, flag_d0x2;
  logic ce_d5,   tog_d5,   flag_d5;
  logic ce_bad,  tog_bad,  flag_bad;
`ifdef CE_DIVIDER_SYNC_CLR_EN
  logic ce_d7,   tog_d7,   flag_d7;
`endif

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT instances
  // ---------------------------------------------------------------------------
  ce_divider_flag #(.CLK_DIVIDE(5'd3), .EXTRA_DIV2("FALSE")) u_d3 (
    .clk(clk), .rst_n(rst_n),
`ifdef CE_DIVIDER_SYNC_CLR_EN
    .clr(clr_off),
`endif
    .ce(ce_d3), .ce_toggle(tog_d3), .flag_toggle_in(flag_in), .flag_out(flag_d3));

  ce_divider_flag #(.CLK_DIVIDE(5'd3), .EXTRA_DIV2("TRUE")) u_d3x2 (
    .clk(clk), .rst_n(rst_n),
`ifdef CE_DIVIDER_SYNC_CLR_EN
    .clr(clr_off),
`endif
    .ce(ce_d3x2), .ce_toggle(tog_d3x2), .flag_toggle_in(flag_in), .flag_out(flag_d3x2));

  ce_divider_flag #(.CLK_DIVIDE(5'd0), .EXTRA_DIV2("FALSE")) u_d0 (
    .clk(clk), .rst_n(rst_n),
`ifdef CE_DIVIDER_SYNC_CLR_EN
    .clr(clr_off),
`endif
    .ce(ce_d0), .ce_toggle(tog_d0), .flag_toggle_in(flag_in), .flag_out(flag_d0));

  ce_divider_flag #(.CLK_DIVIDE(5'd0), .EXTRA_DIV2("TRUE")) u_d0x2 (
    .clk(clk), .rst_n(rst_n),
`ifdef CE_DIVIDER_SYNC_CLR_EN
    .clr(clr_off),
`endif
    .ce(ce_d0x2), .ce_toggle(tog_d0x2), .flag_toggle_in(flag_in), .flag_out(flag_d0x2));

  ce_divider_flag #(.CLK_DIVIDE(5'd5), .EXTRA_DIV2("FALSE")) u_d5 (
    .clk(clk), .rst_n(rst_n),
`ifdef CE_DIVIDER_SYNC_CLR_EN
    .clr(clr_off),
`endif
    .ce(ce_d5), .ce_toggle(tog_d5), .flag_toggle_in(flag_in), .flag_out(flag_d5));

  // An unrecognised EXTRA_DIV2 string must behave like "FALSE" (period 4).
  ce_divider_flag #(.CLK_DIVIDE(5'd3), .EXTRA_DIV2("YES")) u_bad (
    .clk(clk), .rst_n(rst_n),
`ifdef CE_DIVIDER_SYNC_CLR_EN
    .clr(clr_off),
`endif
    .ce(ce_bad), .ce_toggle(tog_bad), .flag_toggle_in(flag_in), .flag_out(flag_bad));

`ifdef CE_DIVIDER_SYNC_CLR_EN
  ce_divider_flag #(.CLK_DIVIDE(5'd7), .EXTRA_DIV2("FALSE")) u_d7 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .ce(ce_d7), .ce_toggle(tog_d7), .flag_toggle_in(flag_in), .flag_out(flag_d7));
`endif

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Checks every divider instance after each of the edges first..last.
  // Edges are counted from reset release.
  task automatic run_edges(input int first, input int last);
    for (int n = first; n <= last; n++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("d3_ce@%0d", n),    ce_d3,   (n % 4 == 0));
      check_val($sformatf("d3_tog@%0d", n),   tog_d3,  ((n - 1) / 4) % 2);
      check_val($sformatf("d3x2_ce@%0d", n),  ce_d3x2, (n % 8 == 0));
      check_val($sformatf("d3x2_tog@%0d", n), tog_d3x2, ((n - 1) / 8) % 2);
      check_val($sformatf("d0_ce@%0d", n),    ce_d0,   1);
      check_val($sformatf("d0_tog@%0d", n),   tog_d0,  (n - 1) % 2);
      check_val($sformatf("d0x2_ce@%0d", n),  ce_d0x2, (n % 2 == 0));
      check_val($sformatf("d0x2_tog@%0d", n), tog_d0x2, ((n - 1) / 2) % 2);
      check_val($sformatf("d5_ce@%0d", n),    ce_d5,   (n % 6 == 0));
      check_val($sformatf("d5_tog@%0d", n),   tog_d5,  ((n - 1) / 6) % 2);
      check_val($sformatf("bad_ce@%0d", n),   ce_bad,  (n % 4 == 0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ce"},   {ce_d3, ce_d3x2, ce_d0, ce_d0x2, ce_d5, ce_bad}, 0);
    check_val({tag, "_tog"},  {tog_d3, tog_d3x2, tog_d0, tog_d0x2, tog_d5, tog_bad}, 0);
    check_val({tag, "_flag"}, {flag_d3, flag_d3x2, flag_d0, flag_d0x2, flag_d5, flag_bad}, 0);
  endtask

  // One edge, then checks flag_out on two instances.
  task automatic flag_step(input string tag, input logic exp);
    @(posedge clk);
    #1;
    check_val({tag, "_d3"}, flag_d3, exp);
    check_val({tag, "_d5"}, flag_d5, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    flag_in = 1'b0;
    clr_off = 1'b0;
    clr     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    $display("reset state checked (%0d compares)", n_cmp);

    @(negedge clk);
    rst_n = 1'b1;
    run_edges(1, 26);
    $display("divider periods checked through edge 26 (%0d compares)", n_cmp);

    // d5 now has count 2 (26 mod 6). Drop rst_n between edges and check that
    // every output clears at once.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    run_edges(1, 14);
    $display("mid-period reset and restart checked (%0d compares)", n_cmp);

    // Rising transition, set up before edge k. Pulse between edges k+1 and k+2.
    @(negedge clk);
    flag_in = 1'b1;
    flag_step("rise_k",   1'b0);
    flag_step("rise_k1",  1'b1);
    flag_step("rise_k2",  1'b0);
    flag_step("rise_k3",  1'b0);
    // Falling transition gives the same single pulse.
    @(negedge clk);
    flag_in = 1'b0;
    flag_step("fall_k",   1'b0);
    flag_step("fall_k1",  1'b1);
    flag_step("fall_k2",  1'b0);
    flag_step("fall_k3",  1'b0);
    // Level held for one cycle only: each of the two edges is flagged in turn,
    // back to back, with nothing after.
    @(negedge clk);
    flag_in = 1'b1;
    flag_step("short_k",  1'b0);
    @(negedge clk);
    flag_in = 1'b0;
    flag_step("short_k1", 1'b1);
    flag_step("short_k2", 1'b1);
    flag_step("short_k3", 1'b0);
    flag_step("short_k4", 1'b0);
    $display("flag receive path checked (%0d compares)", n_cmp);

`ifdef CE_DIVIDER_SYNC_CLR_EN
    // Fresh reset. Period 8: ce after edge 8, ce_toggle high from edge 9. clr
    // at edge 14 (count 5) suppresses the ce due after edge 16. The next ce
    // comes 8 edges later, after edge 22. ce_toggle must survive clr.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      if (n == 14) clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      if (n < 14) begin
        check_val($sformatf("clr_pre_ce@%0d", n), ce_d7, (n == 8));
        check_val($sformatf("clr_pre_tog@%0d", n), tog_d7, (n >= 9));
      end else begin
        check_val($sformatf("clr_post_ce@%0d", n), ce_d7, (n == 22));
        check_val($sformatf("clr_post_tog@%0d", n), tog_d7, (n <= 22));
      end
    end
    $display("synchronous clear checked (%0d compares)", n_cmp);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "testbench timeout");
  end

endmodule
